// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] DEFAULT_TT = 16'hE605;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tt_sweep_watchdog.sv
// Per-vector response watchdog: counts enabled cycles after a clear and
// flags expiry once the count reaches TIMEOUT (saturates there).
module tt_sweep_watchdog
  import tt_sweep_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (count == LIMIT);

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table checker: offers every input vector to an external
// netlist, compares each response bit with a programmable table, reports results.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int                N_IN       = 4,
  parameter int                TT_W       = 2 ** N_IN,
  parameter logic [TT_W-1:0]   DEFAULT_TT = tt_sweep_pkg::DEFAULT_TT,
  parameter int                TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [TT_W-1:0]  cfg_tt,
  input  logic             start,
  output logic             vec_valid,
  output logic [N_IN-1:0]  vec_data,
  input  logic             vec_ready,
  input  logic             rsp_valid,
  input  logic             rsp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    mismatch_cnt,
  output logic [N_IN-1:0]  first_fail_idx,
  output logic             first_fail_vld,
  output logic             timeout_err
);

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_e            state;
  logic [N_IN-1:0]   idx;
  logic [TT_W-1:0]   tt;
  logic [N_IN:0]     mm_cnt;
  logic [N_IN-1:0]   ff_idx;
  logic              ff_vld;
  logic              to_err;
  logic              pass_q;

  logic              wd_expire;
  logic              exp_bit;
  logic              rsp_hit;
  logic              to_hit;
  logic              vec_end;
  logic              miss;
  logic [N_IN:0]     mm_next;

  tt_sweep_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == ST_ISSUE),
    .enable ((state == ST_WAIT) && !rsp_valid),
    .expire (wd_expire)
  );

  // Vector idx maps to table bit TT_W-1-idx, which is simply ~idx in N_IN bits.
  assign exp_bit = tt[~idx];

  assign rsp_hit = (state == ST_WAIT) && rsp_valid;
  assign to_hit  = (state == ST_WAIT) && !rsp_valid && wd_expire;
  assign vec_end = rsp_hit || to_hit;
  assign miss    = to_hit || (rsp_hit && (rsp_data != exp_bit));
  assign mm_next = mm_cnt + (N_IN+1)'(miss);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      tt     <= DEFAULT_TT;
      mm_cnt <= '0;
      ff_idx <= '0;
      ff_vld <= 1'b0;
      to_err <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_we) begin
            tt <= cfg_tt;
          end
          if (start) begin
            mm_cnt <= '0;
            ff_vld <= 1'b0;
            to_err <= 1'b0;
            pass_q <= 1'b0;
            idx    <= '0;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (vec_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (vec_end) begin
            if (miss) begin
              mm_cnt <= mm_next;
              if (!ff_vld) begin
                ff_idx <= idx;
                ff_vld <= 1'b1;
              end
            end
            if (to_hit) begin
              to_err <= 1'b1;
            end
            // pass is resolved on entry to DONE so it is valid alongside done.
            if (idx == LAST_IDX) begin
              pass_q <= (mm_next == '0) && !(to_err || to_hit);
              state  <= ST_DONE;
            end else begin
              idx   <= idx + N_IN'(1);
              state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign vec_valid      = (state == ST_ISSUE);
  assign vec_data       = idx;
  assign busy           = (state == ST_ISSUE) || (state == ST_WAIT);
  assign done           = (state == ST_DONE);
  assign pass           = pass_q;
  assign mismatch_cnt   = mm_cnt;
  assign first_fail_idx = ff_idx;
  assign first_fail_vld = ff_vld;
  assign timeout_err    = to_err;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: behavioural responder with modes for ideal,
// constant, dropped-response, stalled and stray-response netlists.
module tb_tt_sweep_checker;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [15:0] cfg_tt;
  logic        start;
  logic        vec_valid;
  logic [3:0]  vec_data;
  logic        vec_ready;
  logic        rsp_valid;
  logic        rsp_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail_idx;
  logic        first_fail_vld;
  logic        timeout_err;

  int n_chk;
  int n_pass;
  int n_fail;
  int stall_err;
  logic [15:0] mdl_tt;

  tt_sweep_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_we         (cfg_we),
    .cfg_tt         (cfg_tt),
    .start          (start),
    .vec_valid      (vec_valid),
    .vec_data       (vec_data),
    .vec_ready      (vec_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_cnt   (mismatch_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_vld (first_fail_vld),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tt_bit(input logic [15:0] tt, input int idx);
    logic [15:0] t;
    t = tt;
    return t[15-idx];
  endfunction

  // mode 0: ideal netlist for mdl_tt; 1: constant 0; 2: constant 1
  function automatic logic resp_bit(input int mode, input int idx);
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return tt_bit(mdl_tt, idx);
  endfunction

  task automatic run_sweep(input int mode, input int skip, input int max_stall,
                           input bit stray, input int cfg_at, input int abort_at,
                           output int cyc, output bit saw_done);
    int          stall;
    bit          have;
    bit          pend;
    int          pidx;
    logic [3:0]  held;
    stall = 0; have = 0; pend = 0; pidx = 0; held = '0;
    cyc = 0; saw_done = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 3000) begin
      if (done) begin
        saw_done = 1;
        break;
      end
      if (abort_at > 0 && cyc == abort_at) break;
      rsp_valid = 1'b0; rsp_data = 1'b0; vec_ready = 1'b0; cfg_we = 1'b0;
      if (cyc == cfg_at) begin
        cfg_we = 1'b1;
        cfg_tt = 16'h0001;
      end
      if (pend) begin
        if (pidx != skip) begin
          rsp_valid = 1'b1;
          rsp_data  = resp_bit(mode, pidx);
        end
        pend = 0;
      end
      if (vec_valid) begin
        if (!have) begin
          have  = 1;
          held  = vec_data;
          stall = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
        end else if (vec_data !== held) begin
          stall_err++;
        end
        if (stall == 0) begin
          vec_ready = 1'b1;
          pend = 1;
          pidx = int'(vec_data);
          have = 0;
          if (stray) begin
            rsp_valid = 1'b1;
            rsp_data  = ~resp_bit(0, pidx);
          end
        end else begin
          stall--;
        end
      end
      @(negedge clk); cyc++;
    end
    rsp_valid = 1'b0; rsp_data = 1'b0; vec_ready = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    int cyc;
    bit sd;
    n_chk = 0; n_pass = 0; n_fail = 0; stall_err = 0;
    mdl_tt = 16'hE605;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_tt = '0; start = 1'b0;
    vec_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_mm", 32'(mismatch_cnt), 0);
    chk("rst_ffv", 32'(first_fail_vld), 0);
    chk("rst_to", 32'(timeout_err), 0);
    chk("rst_vv", 32'(vec_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 1: ideal zero-wait responder, default table
    run_sweep(0, -1, 0, 0, -1, 0, cyc, sd);
    chk("t1_done_seen", 32'(sd), 1);
    chk("t1_latency", 32'(cyc), 33);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_mm", 32'(mismatch_cnt), 0);
    chk("t1_ffv", 32'(first_fail_vld), 0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_pass_hold", 32'(pass), 1);

    // 2: constant 0 responder
    run_sweep(1, -1, 0, 0, -1, 0, cyc, sd);
    chk("t2_done_seen", 32'(sd), 1);
    chk("t2_mm", 32'(mismatch_cnt), 7);
    chk("t2_ffi", 32'(first_fail_idx), 0);
    chk("t2_ffv", 32'(first_fail_vld), 1);
    chk("t2_pass", 32'(pass), 0);

    // 3: constant 1 responder
    run_sweep(2, -1, 0, 0, -1, 0, cyc, sd);
    chk("t3_mm", 32'(mismatch_cnt), 9);
    chk("t3_ffi", 32'(first_fail_idx), 3);
    chk("t3_pass", 32'(pass), 0);

    // 4: no response for vector 5
    run_sweep(0, 5, 0, 0, -1, 0, cyc, sd);
    chk("t4_done_seen", 32'(sd), 1);
    chk("t4_to", 32'(timeout_err), 1);
    chk("t4_mm", 32'(mismatch_cnt), 1);
    chk("t4_ffi", 32'(first_fail_idx), 5);
    chk("t4_pass", 32'(pass), 0);

    // 5: random ready stalls plus stray response on accept cycle
    stall_err = 0;
    run_sweep(0, -1, 4, 1, -1, 0, cyc, sd);
    chk("t5_done_seen", 32'(sd), 1);
    chk("t5_stable", 32'(stall_err), 0);
    chk("t5_pass", 32'(pass), 1);
    chk("t5_mm", 32'(mismatch_cnt), 0);
    chk("t5_to", 32'(timeout_err), 0);

    // 6a: table write while busy is ignored
    run_sweep(0, -1, 0, 0, 5, 0, cyc, sd);
    chk("t6a_pass", 32'(pass), 1);
    chk("t6a_mm", 32'(mismatch_cnt), 0);

    // 6b: same write in IDLE takes effect (only vector 15 expects 1)
    @(negedge clk); cfg_we = 1'b1; cfg_tt = 16'h0001;
    @(negedge clk); cfg_we = 1'b0; cfg_tt = '0;
    run_sweep(1, -1, 0, 0, -1, 0, cyc, sd);
    chk("t6b_mm", 32'(mismatch_cnt), 1);
    chk("t6b_ffi", 32'(first_fail_idx), 15);
    chk("t6b_pass", 32'(pass), 0);

    // 6c: reset mid-sweep (table 0x0001, constant-1 responder: vectors 0..2 mismatch)
    run_sweep(2, -1, 0, 0, -1, 8, cyc, sd);
    chk("t6c_busy_pre", 32'(busy), 1);
    chk("t6c_mm_pre", 32'(mismatch_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6c_busy", 32'(busy), 0);
    chk("t6c_vv", 32'(vec_valid), 0);
    chk("t6c_mm", 32'(mismatch_cnt), 0);
    chk("t6c_ffv", 32'(first_fail_vld), 0);
    chk("t6c_done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0, -1, 0, 0, -1, 0, cyc, sd);
    chk("t6c_tbl_pass", 32'(pass), 1);
    chk("t6c_tbl_mm", 32'(mismatch_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
